// File: rtl/m_wbregbank_pkg.sv
// ---------------------------------------------------------------------------
// m_wbregbank_pkg
// Shared definitions for the Wishbone register bank:
//   - controller state encodings
//   - indices of the STATUS and MASK registers (used with WBREGBANK_IRQ_EN)
//   - width of the wait-state counter
// ---------------------------------------------------------------------------
package m_wbregbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int STATUS_IDX = 0;
    localparam int MASK_IDX   = 1;

    // Wait-state counter width; WAITSTATES must fit (0..3).
    localparam int WS_W = 2;

endpackage

// File: rtl/m_wbregbank_ackgen.sv
// ---------------------------------------------------------------------------
// m_wbregbank_ackgen
// Bus-cycle controller: IDLE -> (WAIT) -> ACK -> GAP -> IDLE.
//
// Parameters:
//   WAITSTATES  extra cycles between the first sampled strobe and ACK (0..3)
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   stb     in   qualified strobe
//   ack     out  high for exactly one cycle per completed access
//   commit  out  high in the cycle whose closing edge enters ACK; the
//                register bank writes / captures read data on that edge
// ---------------------------------------------------------------------------
module m_wbregbank_ackgen
    import m_wbregbank_pkg::*;
#(
    parameter int WAITSTATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    output logic ack,
    output logic commit
);

    state_t            state_reg;
    state_t            state_next;
    logic [WS_W-1:0]   cnt_reg;
    logic [WS_W-1:0]   cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (stb) begin
                    if (WAITSTATES == 0) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WS_W'(WAITSTATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!stb) begin
                    // Master gave up: abandon the access without acking.
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - WS_W'(1);
                    // Counter reaching zero on this edge means the wait is over.
                    if (cnt_reg == WS_W'(1)) begin
                        state_next = ST_ACK;
                    end
                end
            end
            ST_ACK:  state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ack    = (state_reg == ST_ACK);
        // ACK is never re-entered from ACK, so this is a one-cycle strobe.
        commit = (state_next == ST_ACK) && (state_reg != ST_ACK);
    end

endmodule

// File: rtl/m_wbregbank.sv
// ---------------------------------------------------------------------------
// m_wbregbank
// Wishbone classic slave with NREGS byte-writable 32-bit registers,
// programmable wait states and zeroed read data outside ACK.
//
// Optional feature, macro WBREGBANK_IRQ_EN:
//   register STATUS_IDX becomes sticky event status (set by evt_i,
//   write-1-to-clear, set wins over clear), register MASK_IDX is the mask,
//   irq_o = |(STATUS & MASK), registered. Without the macro all registers
//   are plain read/write, evt_i is ignored and irq_o is 0.
//
// Parameters: NREGS (power of two, 2..16), WAITSTATES (0..3), ADRW (derived)
// Ports:
//   CLK_I   in   clock            RST_I  in   async active-low reset
//   STB_I   in   strobe           WE_I   in   write enable
//   SEL_I   in   byte selects     ADR_I  in   word address
//   DAT_I   in   write data       DAT_O  out  read data (0 outside ACK)
//   ACK_O   out  one-cycle ack    regs_o out  flat register contents
//   evt_i   in   event pulses     irq_o  out  interrupt request
// ---------------------------------------------------------------------------
module m_wbregbank
    import m_wbregbank_pkg::*;
#(
    parameter int NREGS      = 4,
    parameter int WAITSTATES = 0,
    parameter int ADRW       = $clog2(NREGS)
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic                  WE_I,
    input  logic [3:0]            SEL_I,
    input  logic [ADRW-1:0]       ADR_I,
    input  logic [31:0]           DAT_I,
    output logic [31:0]           DAT_O,
    output logic                  ACK_O,
    output logic [32*NREGS-1:0]   regs_o,
    input  logic [31:0]           evt_i,
    output logic                  irq_o
);

`ifdef WBREGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
    logic unused_evt;
    assign unused_evt = ^evt_i;
`endif

    logic                  ack;
    logic                  commit;
    logic [31:0]           wmask;
    logic [32*NREGS-1:0]   regs_flat;
    logic [31:0]           dat_reg;

    m_wbregbank_ackgen #(
        .WAITSTATES (WAITSTATES)
    ) u_ackgen (
        .clk    (CLK_I),
        .rst_n  (RST_I),
        .stb    (STB_I),
        .ack    (ack),
        .commit (commit)
    );

    genvar gi;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{SEL_I[gi]}};
        end

        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic        wr_hit;
            logic [31:0] r_reg;

            assign wr_hit = commit & WE_I & (ADR_I == ADRW'(gi));

            if (IRQ_EN && (gi == STATUS_IDX)) begin : g_status
                // Clear first, then OR in events so a same-cycle event wins.
                always_ff @(posedge CLK_I or negedge RST_I) begin
                    if (!RST_I) begin
                        r_reg <= '0;
                    end else begin
                        r_reg <= (r_reg & ~(wr_hit ? (DAT_I & wmask) : 32'h0)) | evt_i;
                    end
                end
            end else begin : g_plain
                always_ff @(posedge CLK_I or negedge RST_I) begin
                    if (!RST_I) begin
                        r_reg <= '0;
                    end else if (wr_hit) begin
                        r_reg <= (r_reg & ~wmask) | (DAT_I & wmask);
                    end
                end
            end

            assign regs_flat[32*gi +: 32] = r_reg;
        end

        if (IRQ_EN) begin : g_irq
            logic irq_reg;
            always_ff @(posedge CLK_I or negedge RST_I) begin
                if (!RST_I) begin
                    irq_reg <= 1'b0;
                end else begin
                    irq_reg <= |(regs_flat[32*STATUS_IDX +: 32] & regs_flat[32*MASK_IDX +: 32]);
                end
            end
            assign irq_o = irq_reg;
        end else begin : g_noirq
            assign irq_o = 1'b0;
        end
    endgenerate

    // Read data is captured on the edge entering ACK and dropped on the
    // next edge, so the bus sees non-zero data only while ACK_O is high.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            dat_reg <= '0;
        end else if (commit && !WE_I) begin
            dat_reg <= regs_flat[32*ADR_I +: 32];
        end else begin
            dat_reg <= '0;
        end
    end

    assign DAT_O  = dat_reg;
    assign ACK_O  = ack;
    assign regs_o = regs_flat;

endmodule

// File: tb/tb_m_wbregbank.sv
// ---------------------------------------------------------------------------
// tb_m_wbregbank
// Two instances share the bus signals except the strobe: dut0 with
// WAITSTATES=0, dut3 with WAITSTATES=3. A transaction-level model keeps the
// expected register contents; follows WBREGBANK_IRQ_EN if defined.
// ---------------------------------------------------------------------------
module tb_m_wbregbank;

    localparam int NREGS = 4;
    localparam int ADRW  = 2;

`ifdef WBREGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       stb   = '0;
    logic             we    = 1'b0;
    logic [3:0]       sel   = '0;
    logic [ADRW-1:0]  adr   = '0;
    logic [31:0]      dat_w = '0;
    logic [31:0]      evt   = '0;

    logic [31:0]          dat_o  [2];
    logic                 ack    [2];
    logic [32*NREGS-1:0]  regs_o [2];
    logic                 irq    [2];

    logic [31:0] mreg [2][NREGS];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    m_wbregbank #(.NREGS(NREGS), .WAITSTATES(0)) dut0 (
        .CLK_I (clk), .RST_I (rst_n), .STB_I (stb[0]), .WE_I (we),
        .SEL_I (sel), .ADR_I (adr), .DAT_I (dat_w), .DAT_O (dat_o[0]),
        .ACK_O (ack[0]), .regs_o (regs_o[0]), .evt_i (evt), .irq_o (irq[0])
    );

    m_wbregbank #(.NREGS(NREGS), .WAITSTATES(3)) dut3 (
        .CLK_I (clk), .RST_I (rst_n), .STB_I (stb[1]), .WE_I (we),
        .SEL_I (sel), .ADR_I (adr), .DAT_I (dat_w), .DAT_O (dat_o[1]),
        .ACK_O (ack[1]), .regs_o (regs_o[1]), .evt_i (evt), .irq_o (irq[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic logic exp_irq(input int d);
        return IRQ_EN ? (|(mreg[d][0] & mreg[d][1])) : 1'b0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NREGS; k++) mreg[d][k] = '0;
    endtask

    // One complete access on instance d; evt stays constant throughout.
    task automatic bus(input int d, input bit w, input int a, input logic [31:0] v, input logic [3:0] s);
        int          cyc;
        bit          got;
        logic [31:0] exp_rd;
        logic [31:0] m;
        exp_rd = mreg[d][a];
        we = w; adr = ADRW'(a); dat_w = v; sel = s; stb[d] = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            got = ack[d];
        end
        check($sformatf("latency d%0d a%0d", d, a), cyc, (d == 1) ? 4 : 1);
        if (!w) check($sformatf("read d%0d a%0d", d, a), dat_o[d], exp_rd);
        if (w) begin
            m = bmask(s);
            if (IRQ_EN && a == 0) mreg[d][0] = mreg[d][0] & ~(v & m);
            else                  mreg[d][a] = (mreg[d][a] & ~m) | (v & m);
        end
        if (IRQ_EN) for (int dd = 0; dd < 2; dd++) mreg[dd][0] = mreg[dd][0] | evt;
        stb[d] = 1'b0; we = 1'b0;
        tick();
        check($sformatf("gap ack d%0d", d), ack[d], 1'b0);
        check($sformatf("gap dat d%0d", d), dat_o[d], 32'h0);
        check($sformatf("regs_o d%0d a%0d", d, a), regs_o[d][32*a +: 32], mreg[d][a]);
        tick();
        for (int dd = 0; dd < 2; dd++) check($sformatf("irq d%0d", dd), irq[dd], exp_irq(dd));
    endtask

    task automatic pulse_evt(input logic [31:0] v);
        logic prev [2];
        for (int d = 0; d < 2; d++) prev[d] = exp_irq(d);
        evt = v;
        tick();
        evt = '0;
        if (IRQ_EN) for (int d = 0; d < 2; d++) mreg[d][0] = mreg[d][0] | v;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("evt status d%0d", d), regs_o[d][31:0], mreg[d][0]);
            check($sformatf("irq lag d%0d", d), irq[d], prev[d]);
        end
        tick();
        for (int d = 0; d < 2; d++) check($sformatf("irq after evt d%0d", d), irq[d], exp_irq(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, acks;
        bit w;
        int d, a;
        model_clear();

        // Reset state
        tick(); tick();
        for (int dd = 0; dd < 2; dd++) begin
            check($sformatf("reset ack d%0d", dd), ack[dd], 1'b0);
            check($sformatf("reset dat d%0d", dd), dat_o[dd], 32'h0);
            check($sformatf("reset irq d%0d", dd), irq[dd], 1'b0);
            for (int k = 0; k < NREGS; k++)
                check($sformatf("reset reg d%0d k%0d", dd, k), regs_o[dd][32*k +: 32], 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // Basic read, byte-lane write and readback
        bus(0, 1'b0, 2, 32'h0, 4'hF);
        bus(0, 1'b1, 3, 32'hDEADBEEF, 4'b0101);
        check("sel0101 regs_o", regs_o[0][127:96], 32'h00AD00EF);
        bus(0, 1'b0, 3, 32'h0, 4'hF);
        bus(0, 1'b1, 2, 32'hCAFEF00D, 4'b0000);

        // Register 0 plain write (or W1C with the interrupt feature)
        bus(0, 1'b1, 0, 32'h12345678, 4'hF);
        bus(0, 1'b0, 0, 32'h0, 4'hF);
        bus(1, 1'b1, 0, 32'h12345678, 4'hF);
        bus(1, 1'b0, 0, 32'h0, 4'hF);

        // Event / interrupt sequence
        bus(0, 1'b1, 0, 32'hFFFFFFFF, 4'hF);
        bus(0, 1'b1, 1, 32'h00000001, 4'hF);
        pulse_evt(32'h00000001);
        bus(0, 1'b1, 0, 32'h00000001, 4'hF);
        evt = 32'h00000001;
        bus(0, 1'b1, 0, 32'h00000001, 4'hF);
        evt = '0;
        bus(0, 1'b0, 0, 32'h0, 4'hF);
        pulse_evt(32'hFFFFFFFF);

        // Held strobe with wait states: ack spacing
        we = 1'b0; adr = 2'd1; sel = 4'hF; stb[1] = 1'b1;
        first = -1; second = -1;
        for (int c = 1; c <= 20 && second < 0; c++) begin
            tick();
            if (ack[1]) begin
                if (first < 0) first = c;
                else           second = c;
            end
        end
        stb[1] = 1'b0;
        check("held first ack", first, 4);
        check("held ack spacing", second - first, 6);
        tick(); tick();

        // Aborted write
        bus(1, 1'b1, 2, 32'hA5A5A5A5, 4'hF);
        we = 1'b1; adr = 2'd2; dat_w = 32'h11112222; sel = 4'hF; stb[1] = 1'b1;
        tick(); tick();
        stb[1] = 1'b0; we = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack[1]) acks++;
        end
        check("abort acks", acks, 0);
        check("abort reg2", regs_o[1][95:64], mreg[1][2]);
        bus(1, 1'b0, 2, 32'h0, 4'hF);

        // Reset during the wait phase of a write
        we = 1'b1; adr = 2'd2; dat_w = 32'h33334444; sel = 4'hF; stb[1] = 1'b1;
        tick(); tick();
        check("pre-reset ack", ack[1], 1'b0);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("reset mid reg2", regs_o[1][95:64], 32'h0);
        check("reset mid ack", ack[1], 1'b0);
        stb[1] = 1'b0; we = 1'b0;
        tick();
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack[1]) acks++;
        end
        check("post-reset acks", acks, 0);
        bus(1, 1'b0, 2, 32'h0, 4'hF);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, NREGS - 1));
            evt = (w && $urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            bus(d, w, a, $urandom, 4'($urandom_range(0, 15)));
            evt = '0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
